// File: rtl/alu_vote_pkg.sv
// Shared types and helpers for the N-modular-redundant ALU vote controller.
//   state_t    : controller FSM states
//   ALU_*      : ALU control encodings carried on req_cont/alu_cont
//   popcount() : number of set bits in a vector of up to 64 bits
package alu_vote_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        CHECK,
        DONE,
        FAIL
    } state_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/alu_vote_ctrl_voter.sv
// rep_voter: combinational per-bit majority over NREP masked replica words.
//   data     : NREP words of W bits, replica i at [i*W +: W]
//   en       : enabled-replica mask; disabled words take no part in the vote
//   vote     : bit b is 1 iff (enabled ones at b)*2 > enabled count (tie -> 0)
//   mismatch : enabled replicas whose whole word differs from the vote
module rep_voter #(
    parameter int NREP = 8,
    parameter int W    = 33
) (
    input  logic [NREP*W-1:0] data,
    input  logic [NREP-1:0]   en,
    output logic [W-1:0]      vote,
    output logic [NREP-1:0]   mismatch
);

    localparam int CW = $clog2(NREP + 1);

    logic [CW-1:0] en_cnt;
    logic [CW-1:0] ones;

    always_comb begin
        en_cnt = '0;
        for (int i = 0; i < NREP; i++) begin
            en_cnt = en_cnt + CW'(en[i]);
        end
    end

    // One extra bit on both sides so ones*2 cannot overflow.
    always_comb begin
        vote = '0;
        ones = '0;
        for (int b = 0; b < W; b++) begin
            ones = '0;
            for (int i = 0; i < NREP; i++) begin
                ones = ones + CW'(en[i] & data[i*W + b]);
            end
            vote[b] = ({ones, 1'b0} > {1'b0, en_cnt});
        end
    end

    always_comb begin
        mismatch = '0;
        for (int i = 0; i < NREP; i++) begin
            mismatch[i] = en[i] && (data[i*W +: W] != vote);
        end
    end

endmodule

// File: rtl/alu_vote_ctrl.sv
// alu_vote_ctrl: sequencing and fault-management controller for an
// N-modular-redundant ALU. Accepts one operation, holds operands for LAT
// cycles, majority-votes the replica results and zero flags, retires
// replicas after STRIKES consecutive mismatches and goes fatal when fewer
// than MIN_REP replicas remain.
//   clk, reset (sync, active-low)
//   req_*   : requester operation handshake and operands
//   alu_*   : registered operands/control to all replicas
//   rep_*   : replica results/zero flags in, enabled mask out
//   resp_*  : voted response handshake
//   fault_cnt, fatal : health status
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request
// EXEC  | operands held on alu_*, latency counter running down
// CHECK | vote sampled, response registered, strikes/rep_en updated
// DONE  | response valid, waiting for resp_ready
// FAIL  | too few replicas left; terminal until reset
module alu_vote_ctrl
    import alu_vote_pkg::*;
#(
    parameter int NREP    = 8,
    parameter int WIDTH   = 32,
    parameter int LAT     = 1,
    parameter int STRIKES = 2,
    parameter int MIN_REP = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [WIDTH-1:0]           req_a,
    input  logic [WIDTH-1:0]           req_b,
    input  logic [2:0]                 req_cont,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output logic [2:0]                 alu_cont,
    input  logic [NREP*WIDTH-1:0]      rep_result,
    input  logic [NREP-1:0]            rep_zero,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [WIDTH-1:0]           resp_result,
    output logic                       resp_zero,
    output logic [NREP-1:0]            rep_en,
    output logic [$clog2(NREP+1)-1:0]  fault_cnt,
    output logic                       fatal
);

    localparam int VW = WIDTH + 1;
    localparam int SW = $clog2(STRIKES + 1);
    localparam int FW = $clog2(NREP + 1);
    localparam int LW = (LAT > 1) ? $clog2(LAT) : 1;

    state_t state, state_next;

    logic [LW-1:0]        lat_cnt;
    logic [SW-1:0]        strike      [NREP];
    logic [SW-1:0]        strike_next [NREP];
    logic [NREP-1:0]      en_next;
    logic [NREP*VW-1:0]   vote_data;
    logic [VW-1:0]        vote;
    logic [NREP-1:0]      mismatch;

    // Zero flag rides as the top bit so one voter covers both.
    always_comb begin
        vote_data = '0;
        for (int i = 0; i < NREP; i++) begin
            vote_data[i*VW +: VW] = {rep_zero[i], rep_result[i*WIDTH +: WIDTH]};
        end
    end

    rep_voter #(
        .NREP (NREP),
        .W    (VW)
    ) u_voter (
        .data     (vote_data),
        .en       (rep_en),
        .vote     (vote),
        .mismatch (mismatch)
    );

    // Disabled replicas keep their strike count frozen.
    always_comb begin
        en_next = rep_en;
        for (int i = 0; i < NREP; i++) begin
            strike_next[i] = strike[i];
            if (rep_en[i]) begin
                if (mismatch[i]) begin
                    if (strike[i] != SW'(STRIKES)) begin
                        strike_next[i] = strike[i] + SW'(1);
                    end
                    if (strike_next[i] == SW'(STRIKES)) begin
                        en_next[i] = 1'b0;
                    end
                end else begin
                    strike_next[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        fatal      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = EXEC;
            end
            EXEC: begin
                if (lat_cnt == '0) state_next = CHECK;
            end
            CHECK: begin
                state_next = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = (int'(popcount(64'(rep_en))) < MIN_REP) ? FAIL : IDLE;
                end
            end
            FAIL: begin
                fatal = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_cont    <= '0;
            lat_cnt     <= '0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
            rep_en      <= '1;
            fault_cnt   <= '0;
            for (int i = 0; i < NREP; i++) strike[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        alu_a    <= req_a;
                        alu_b    <= req_b;
                        alu_cont <= req_cont;
                        lat_cnt  <= LW'(LAT - 1);
                    end
                end
                EXEC: begin
                    if (lat_cnt != '0) lat_cnt <= lat_cnt - LW'(1);
                end
                CHECK: begin
                    resp_result <= vote[WIDTH-1:0];
                    resp_zero   <= vote[WIDTH];
                    rep_en      <= en_next;
                    fault_cnt   <= FW'(NREP - int'(popcount(64'(en_next))));
                    for (int i = 0; i < NREP; i++) strike[i] <= strike_next[i];
                end
                default: ;
            endcase
        end
    end

endmodule
